// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package fetch_pkg;
  localparam int unsigned INS_WIDTH = 32;
  localparam int unsigned INS_BYTES = 4;

  typedef struct packed {
    logic [31:0]          pc;
    logic [INS_WIDTH-1:0] ins;
  } fetch_entry_t;

  function automatic logic [31:0] pc_to_word(input logic [31:0] pc);
    return pc >> 2;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; head is read straight from registered storage.
// Flush wins over push/pop; the caller guarantees no push when full and no pop when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_dat,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head_dat,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: PC-driven SRAM reads into a FIFO toward decode; out_valid 2 cycles after issue.
// Issue is throttled by FIFO count plus the read in flight, so held-off decode never loses a word.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [31:0] LAST_PC    = 32'h2b4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ins_req,
  output logic [ADDR_WIDTH-1:0] ins_addr,
  input  logic [DATA_WIDTH-1:0] ins_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_ins,
  output logic [31:0]           out_pc,
  output logic                  empty,
  output logic                  halted
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             fifo_empty;
  logic             push, pop;
  fetch_entry_t     push_dat, head_dat;

  // The read in flight already owns a FIFO slot.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign ins_req   = rst_n && !stop_q && !redirect_valid && (32'(occupancy) < DEPTH);
  assign ins_addr  = ADDR_WIDTH'(pc_to_word(pc_q));

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    stop_d        = stop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~32'h3;
      stop_d = 1'b0;
    end else if (ins_req) begin
      inflight_pc_d = pc_q;
      pc_d          = pc_q + 32'(INS_BYTES);
      inflight_d    = 1'b1;
      if (pc_q == LAST_PC) stop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      stop_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      stop_q        <= stop_d;
    end
  end

  assign push         = inflight_q && !redirect_valid;
  assign pop          = !fifo_empty && out_ready && !redirect_valid;
  assign push_dat.pc  = inflight_pc_q;
  assign push_dat.ins = ins_data;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_dat(push_dat),
    .pop     (pop),
    .flush   (redirect_valid),
    .head_dat(head_dat),
    .count   (count),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_ins   = head_dat.ins;
  assign out_pc    = head_dat.pc;
  assign empty     = fifo_empty;
  assign halted    = stop_q && !inflight_q && fifo_empty;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an SRAM model and a PC scoreboard on the decode side.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ins_req;
  logic [11:0] ins_addr;
  logic [31:0] ins_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        empty;
  logic        halted;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_iss;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  fetch_queue #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .DEPTH     (4),
    .RESET_PC  (32'h0),
    .LAST_PC   (32'h10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ins_req       (ins_req),
    .ins_addr      (ins_addr),
    .ins_data      (ins_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ins       (out_ins),
    .out_pc        (out_pc),
    .empty         (empty),
    .halted        (halted)
  );

  // SRAM: one-cycle read latency, garbage when no read was issued.
  always @(posedge clk)
    ins_data <= ins_req ? ({20'h0, ins_addr} ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

  function automatic logic [31:0] exp_ins(input logic [31:0] pc);
    return {20'h0, pc[13:2]} ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(ins_req), 32'd0);
    chk({tag, "_addr"}, 32'(ins_addr), 32'd0);
    chk({tag, "_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_ins"}, out_ins, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  // Decode-side scoreboard: every accepted head must match the next expected PC.
  always begin : monitor
    logic [31:0] e;
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_ins", out_ins, exp_ins(e));
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    chk_reset_outputs("rst");

    // Streaming from reset up to LAST_PC, then halt.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p <= 16; p += 4) sb.push_back(32'(p));
    #1;
    chk("c0_req", 32'(ins_req), 32'd1);
    chk("c0_addr", 32'(ins_addr), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (k >= 2 && k <= 6) begin
        chk("stream_vld", 32'(out_valid), 32'd1);
        chk("stream_pc", out_pc, 32'((k - 2) * 4));
      end
      if (k >= 5) chk("stop_noreq", 32'(ins_req), 32'd0);
      if (k == 6) chk("halt_early", 32'(halted), 32'd0);
      if (k == 7) chk("halt_rise", 32'(halted), 32'd1);
      if (k == 8) chk("stream_drained", 32'(sb.size()), 32'd0);
    end

    // Back-pressure: redirect to 0 (low bits ignored) with decode stalled.
    @(negedge clk);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0003;
    #1;
    chk("bp_redir_noreq", 32'(ins_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int p = 0; p <= 16; p += 4) sb.push_back(32'(p));
    n_iss = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (ins_req) n_iss++;
      if (k == 1) begin
        chk("bp_halt_clear", 32'(halted), 32'd0);
        chk("bp_addr", 32'(ins_addr), 32'd0);
      end
    end
    chk("bp_issues", 32'(n_iss), 32'd4);
    chk("bp_vld", 32'(out_valid), 32'd1);
    chk("bp_head", out_pc, 32'h0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Redirect with a read in flight.
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    sb.push_back(32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rf_addr8", 32'(ins_addr), 32'd2);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    out_ready      = 1'b0;
    #1;
    chk("rf_noreq", 32'(ins_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("rf_r1_req", 32'(ins_req), 32'd1);
    chk("rf_r1_addr", 32'(ins_addr), 32'h040);
    chk("rf_r1_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rf_r2_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rf_r3_vld", 32'(out_valid), 32'd1);
    chk("rf_r3_pc", out_pc, 32'h100);
    chk("rf_r3_ins", out_ins, exp_ins(32'h100));
    @(negedge clk);

    // Redirect with a simultaneous pop at count 3; target crosses the SRAM address wrap.
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3FF8;
    out_ready      = 1'b1;
    #1;
    chk("rp_noreq", 32'(ins_req), 32'd0);
    chk("rp_sb_clean", 32'(sb.size()), 32'd0);
    sb.push_back(32'h3FF8);
    sb.push_back(32'h3FFC);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("rp_r1_vld", 32'(out_valid), 32'd0);
    chk("rp_r1_addr", 32'(ins_addr), 32'hFFE);
    @(negedge clk);
    #1;
    chk("rp_r2_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rp_r3_pc", out_pc, 32'h3FF8);
    chk("wrap_addr", 32'(ins_addr), 32'h000);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("wrap_pc_full", out_pc, 32'h4000);

    // Reset pulse mid-stream.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    chk("mid_rst_sb", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int p = 0; p <= 16; p += 4) sb.push_back(32'(p));
    #1;
    chk("post_rst_req", 32'(ins_req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("post_rst_vld", 32'(out_valid), 32'd1);
    chk("post_rst_pc", out_pc, 32'h0);
    repeat (5) @(negedge clk);
    #1;
    chk("post_rst_halted", 32'(halted), 32'd1);
    chk("post_rst_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
